// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end: widths, reset/halt encodings,
// fetch state type and the prefetch entry layout.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF   = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_INSTR_DEF = 16'hFFFF;

  typedef enum logic [0:0] {
    StFetch,
    StHalted
  } fetch_state_e;

  // One prefetch FIFO entry: the fetched word and the byte address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sequential PC step; the carry out of bit 15 is dropped so 16'hFFFE wraps to 0.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(2);
  endfunction

  // Instructions are halfword aligned; bit 0 of any target is forced to zero.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, synchronous flush, occupancy count and a
// registered head so decode sees the oldest entry straight from flops.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = INSTR_W + ADDR_W,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok, push_ok;

  // Guard against popping empty or pushing full without a same-cycle pop.
  assign pop_ok     = pop_i && (count_q != '0);
  assign push_ok    = push_i && ((count_q != FULL_CNT) || pop_ok);
  // Depth is a power of two, so pointers wrap naturally.
  assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // Pointer, count and head next-state; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_inc;
      if (pop_ok)  rd_ptr_d = rd_ptr_inc;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
      // The next head is either the entry behind the popped one, or the word being
      // written when the FIFO is (or is about to become) empty. Otherwise hold.
      if (pop_ok && (count_q > ONE_CNT)) begin
        head_d = mem_q[rd_ptr_inc];
      end else if (push_ok && ((count_q == '0) || pop_ok)) begin
        head_d = wdata_i;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; written at the tail on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, fetches from a combinational
// word-addressed memory, buffers words in the prefetch FIFO and hands them to
// decode. Handles stall, redirect/flush, PC wrap and the halt opcode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC   = RESET_PC_DEF,
  parameter int unsigned        DEPTH      = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted,
  output logic               err_misalign
);

  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              pop, push;
  fetch_entry_t      wentry, head;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // Redirect suppresses the push; a full FIFO accepts only alongside a pop.
  assign push      = (state_q == StFetch) && fetch_en && !redirect_valid && (!full || pop);

  assign wentry.instr = imem_instr;
  assign wentry.pc    = pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (count),
    .head_o  (head)
  );

  // PC, state and misalign-flag next-state; redirect takes priority over fetch.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    err_d   = 1'b0;
    if (redirect_valid) begin
      pc_d    = align_pc(redirect_pc);
      state_d = StFetch;
      err_d   = redirect_pc[0];
    end else if (push) begin
      pc_d = pc_incr(pc_q);
      // The halt word is itself buffered; fetching stops after it.
      if (imem_instr == HALT_INSTR) state_d = StHalted;
    end
  end

  // PC, state and misalign-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= StFetch;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_instr    = head.instr;
  assign out_pc       = head.pc;
  assign halted       = (state_q == StHalted);
  assign err_misalign = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        err_misalign;

  localparam int DEPTH = 2;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .err_misalign   (err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed program memory, read combinationally.
  logic [15:0] mem [0:32767];
  assign imem_instr = mem[imem_addr[15:1]];

  int tests = 0;
  int fails = 0;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;
  logic        m_halt;
  logic        m_err;

  task automatic model_reset();
    mq.delete();
    m_pc   = 16'h0000;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_model();
    check1("valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check16("instr", out_instr, mq[0].instr);
      check16("pc", out_pc, mq[0].pc);
    end
    check16("imem_addr", imem_addr, m_pc);
    check1("halted", halted, m_halt);
    check1("err_misalign", err_misalign, m_err);
  endtask

  // One clock: predict from current inputs and model state, clock, then compare.
  task automatic step();
    bit   pop, push;
    ent_t e;
    pop     = (mq.size() != 0) && out_ready;
    push    = !m_halt && fetch_en && !redirect_valid && ((mq.size() < DEPTH) || pop);
    e.instr = mem[m_pc[15:1]];
    e.pc    = m_pc;
    @(posedge clk);
    if (redirect_valid) begin
      mq.delete();
      m_pc   = {redirect_pc[15:1], 1'b0};
      m_halt = 1'b0;
      m_err  = redirect_pc[0];
    end else begin
      m_err = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        m_pc = m_pc + 16'd2;
        if (e.instr == 16'hFFFF) m_halt = 1'b1;
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must clear before any edge.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check1("async_rst_valid", out_valid, 1'b0);
    check16("async_rst_addr", imem_addr, 16'h0000);
    check1("async_rst_halted", halted, 1'b0);
    check16("async_rst_out_pc", out_pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        en, rdy, rv;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] ei, ep, ea;
    logic        eh, ee;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv,
                              input logic [15:0] rpc, input logic ev, input logic [15:0] ei,
                              input logic [15:0] ep, input logic [15:0] ea, input logic eh,
                              input logic ee);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.eh = eh; v.ee = ee;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    logic [15:0] w;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;

    // Random program with occasional halt words, then fixed words for directed tests.
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0000;
      if ($urandom_range(0, 19) == 0) w = 16'hFFFF;
      mem[i] = w;
    end
    mem[0]      = 16'h1111;
    mem[1]      = 16'h2222;
    mem[2]      = 16'h3333;
    mem[3]      = 16'hFFFF;
    mem[4]      = 16'h4444;
    mem[16'h80] = 16'h0A0A;
    mem[16'h81] = 16'h0B0B;
    mem[15'h7FFE] = 16'h7E7E;
    mem[15'h7FFF] = 16'h7F7F;

    //               en    rdy   rv    rpc       ev    instr     pc        addr      hlt   err
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000, 16'h0002, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'h0002, 16'h0004, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333, 16'h0004, 16'h0006, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0006, 16'h0008, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0008, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'h0000, 16'h0002, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0A0A, 16'h0100, 16'h0102, 1'b0, 1'b0);

    do_reset();
    check1("reset_valid", out_valid, 1'b0);
    check16("reset_instr", out_instr, 16'h0000);
    check16("reset_out_pc", out_pc, 16'h0000);
    check16("reset_addr", imem_addr, 16'h0000);
    check1("reset_halted", halted, 1'b0);
    check1("reset_err", err_misalign, 1'b0);

    for (int i = 0; i < NV; i++) begin
      fetch_en       = vecs[i].en;
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(posedge clk);
      #1;
      check1($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check16($sformatf("vec%0d_instr", i), out_instr, vecs[i].ei);
        check16($sformatf("vec%0d_pc", i), out_pc, vecs[i].ep);
      end
      check16($sformatf("vec%0d_addr", i), imem_addr, vecs[i].ea);
      check1($sformatf("vec%0d_halted", i), halted, vecs[i].eh);
      check1($sformatf("vec%0d_err", i), err_misalign, vecs[i].ee);
    end

    // Back-pressure: exactly DEPTH pushes, PC frozen, then in-order drain into halt.
    do_reset();
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    repeat (5) step();
    check16("bp_addr_frozen", imem_addr, 16'h0004);
    check16("bp_head_pc", out_pc, 16'h0000);
    out_ready = 1'b1;
    step();
    check16("bp_second_pc", out_pc, 16'h0002);
    repeat (5) step();
    check1("bp_halted", halted, 1'b1);

    // Redirect while full, then a misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    out_ready      = 1'b0;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    step();
    check1("redir_flush_valid", out_valid, 1'b0);
    check16("redir_addr", imem_addr, 16'h0100);
    redirect_valid = 1'b0;
    step();
    check16("redir_head_pc", out_pc, 16'h0100);
    check16("redir_head_instr", out_instr, 16'h0A0A);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0101;
    step();
    check1("misalign_pulse", err_misalign, 1'b1);
    check16("misalign_addr", imem_addr, 16'h0100);
    redirect_valid = 1'b0;
    step();
    check1("misalign_clear", err_misalign, 1'b0);

    // PC wrap across 16'hFFFE.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check16("wrap_pc0", out_pc, 16'hFFFC);
    step();
    check16("wrap_pc1", out_pc, 16'hFFFE);
    step();
    check16("wrap_pc2", out_pc, 16'h0000);
    check16("wrap_addr", imem_addr, 16'h0002);

    // Stall, then asynchronous reset mid-stream.
    fetch_en = 1'b0;
    repeat (3) step();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    step();
    mid_reset();
    check_model();

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      fetch_en       = ($urandom_range(0, 7) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      redirect_pc    = 16'($urandom);
      if ($urandom_range(0, 499) == 0) mid_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator for the 16-bit CPU. Owns the PC and drives the byte address into the combinational, word-addressed instruction memory. Captures the returned 16-bit word the same cycle.
- Fetched words are buffered with their PC in a small prefetch FIFO and handed to decode over a valid/ready handshake.
- Handles stall, branch redirect/flush, wrap-around and a halt opcode.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, at least 2.
- HALT_INSTR, 16'hFFFF, encoding that stops fetching once it has been buffered.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  16  byte address to instruction memory; bit0 is always 0.
- imem_instr  in  16  combinational read data for imem_addr, valid the same cycle.
- fetch_en  in  1  fetch enable; 0 stalls new fetches but draining continues.
- redirect_valid  in  1  branch/jump taken; flush and reload the PC.
- redirect_pc  in  16  target byte address.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  16  head instruction word.
- out_pc  out  16  byte address of the head instruction.
- halted  out  1  high in the HALTED state.
- err_misalign  out  1  one-cycle pulse when redirect_pc[0] = 1.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, FIFO count = 0, state = FETCH.
  - out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, err_misalign = 0.
- imem_addr = pc at all times (registered PC, no combinational path from inputs).
- pop = out_valid && out_ready. Removes the head at the clock edge.
- push = state==FETCH && fetch_en && !redirect_valid && (count < DEPTH || pop).
  - On push: write {imem_instr, pc} at the tail and set pc <= pc + 2, mod 2^16 (16'hFFFE wraps to 16'h0000).
  - Fetch-to-out_valid latency is 1 cycle. Sustained throughput is 1 instruction per cycle when out_ready stays high.
- Simultaneous push and pop: count is unchanged. Push while full is allowed only with a same-cycle pop.
- out_valid = (count != 0). out_instr/out_pc are the head entry, driven from registers. When empty they hold the last value and are don't-care.
- Redirect has priority over every other event in the cycle:
  - Next cycle: count = 0 and pc = {redirect_pc[15:1], 1'b0}; state goes to FETCH (also out of HALTED).
  - A pop in the redirect cycle is a completed handshake; decode owns that instruction.
  - No push occurs in the redirect cycle.
  - If redirect_pc[0] = 1, err_misalign = 1 for exactly the next cycle; otherwise 0.
- State machine:
  - FETCH -> HALTED when a push writes a word equal to HALT_INSTR. The halt word itself is buffered and delivered.
  - HALTED: no pushes and pc holds; the FIFO still drains and halted = 1.
  - HALTED -> FETCH only on redirect_valid.
- fetch_en = 0: pc and the FIFO tail are frozen; pops still proceed.
- Reset asserted mid-operation: immediately returns to reset values. In-flight FIFO contents are discarded.
- Widths: every address is 16 bits; the PC adder drops its carry.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W = 16, INSTR_W = 16.
  - RESET_PC default and the HALT_INSTR encoding.
  - Fetch state enum {FETCH, HALTED}.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH, width INSTR_W + ADDR_W.
  - Push/pop, synchronous flush, count, async active-low reset.
  - Registered head output.
- fetch_unit keeps the PC, state machine and redirect logic.

Test Plan:
- Reset with program 0x1111, 0x2222, 0x3333 at bytes 0, 2, 4 and out_ready = 1 -> imem_addr sequence 0, 2, 4. out_valid rises 1 cycle after reset release; out_instr/out_pc = 1111/0000, 2222/0002, 3333/0004 on consecutive cycles.
- out_ready = 0 for 5 cycles -> exactly DEPTH = 2 pushes, pc = 0x0004 and frozen, then out_ready = 1 -> in-order delivery with no loss or duplicate.
- Redirect to 0x0100 while the FIFO is full -> next cycle out_valid = 0 and imem_addr = 0x0100; the cycle after, out_pc = 0x0100. A redirect to 0x0101 also pulses err_misalign for 1 cycle and fetches from 0x0100.
- Word 0xFFFF at 0x0006 -> it is delivered with out_pc = 0x0006, then halted = 1 and imem_addr holds at 0x0008; a redirect to 0x0000 clears halted.
- pc preset near the top via redirect to 0xFFFC -> fetches at 0xFFFC, 0xFFFE, 0x0000, with out_pc showing the wrap.
- Toggle fetch_en low for 3 cycles and assert rst_n low mid-stream -> no pushes while stalled; on reset, out_valid = 0 immediately (async) and pc = RESET_PC.
